break_arbiter: RTL

BREAK_ARBITER -- requirements
Module: break_arbiter

---
 rtl/break_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/break_arbiter.sv
// ---------------------------------------------------------------------------
// break_arbiter
//
// Arbitrates four data-break devices onto a single CPU data-break channel.
// An IDLE cycle picks a winner round-robin and latches its address, write word
// and direction. The block then requests the break (REQ) and follows the CPU
// through the break cycle (BUSY). It pulses done to the winner (DONE) and
// returns to IDLE.
//
// Handshake: a device holds req high until it is granted. Once the grant is
// latched the break is committed, so dropping req later has no effect. The
// CPU acknowledges data_break by raising break_in_prog and ends the break by
// lowering it. done is the one-cycle completion strobe back to the device.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   req[3:0]       per-device break request (level)
//   dev_wr[3:0]    per-device direction, 1 = device writes memory
//   dev_addr[59:0] four 15-bit break addresses, device n at [15n+14:15n]
//   dev_wdata[47:0] four 12-bit write words, device n at [12n+11:12n]
//   break_in_prog  CPU is executing the break cycle
//   data_break     break request to the CPU sequencer
//   to_disk        1 = memory read toward device (~dev_wr of winner)
//   break_addr     latched address of the granted device
//   break_wdata    latched write word of the granted device
//   grant[3:0]     one-hot granted device, 0 when none
//   done[3:0]      one-cycle completion pulse to the granted device
//   break_err      sticky watchdog error
//   break_count    completed breaks, 12-bit wrapping
//   fsm_state      current FSM state (debug visibility)
// ---------------------------------------------------------------------------
module break_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [3:0]  dev_wr,
    input  logic [59:0] dev_addr,
    input  logic [47:0] dev_wdata,
    input  logic        break_in_prog,
    output logic        data_break,
    output logic        to_disk,
    output logic [14:0] break_addr,
    output logic [11:0] break_wdata,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic        break_err,
    output logic [11:0] break_count,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Last BUSY cycle index before the watchdog fires (7 BUSY cycles: 0..6).
    localparam logic [2:0] WDOG_LAST = 3'd6;

    state_t      state;
    state_t      next_state;
    logic [1:0]  ptr;
    logic [1:0]  winner;
    logic [2:0]  wdog;

    logic        found;
    logic [1:0]  sel;
    logic [1:0]  cand;
    logic        wdog_fire;

    logic [14:0] addr_arr  [4];
    logic [11:0] wdata_arr [4];

    // Unpack the flat device buses so the winner can be indexed directly.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            addr_arr[i]  = dev_addr[15*i +: 15];
            wdata_arr[i] = dev_wdata[12*i +: 12];
        end
    end

    // Round-robin pick: scan ptr, ptr+1, ptr+2, ptr+3 (mod 4); first hit wins.
    always_comb begin
        found = 1'b0;
        sel   = ptr;
        cand  = ptr;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Next-state logic. break_in_prog is only looked at in REQ and BUSY, so
    // a stray level in IDLE or DONE is ignored.
    always_comb begin
        next_state = state;
        wdog_fire  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (found) next_state = ST_REQ;
            end
            ST_REQ: begin
                if (break_in_prog) next_state = ST_BUSY;
            end
            ST_BUSY: begin
                if (!break_in_prog) begin
                    next_state = ST_DONE;
                end else if (wdog == WDOG_LAST) begin
                    next_state = ST_DONE;
                    wdog_fire  = 1'b1;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            ptr         <= 2'd0;
            winner      <= 2'd0;
            wdog        <= 3'd0;
            to_disk     <= 1'b0;
            break_addr  <= 15'd0;
            break_wdata <= 12'd0;
            grant       <= 4'd0;
            break_err   <= 1'b0;
            break_count <= 12'd0;
        end else begin
            state <= next_state;
            case (state)
                ST_IDLE: begin
                    // Latch everything about the winner now; it stays frozen
                    // until DONE is left, whatever the devices do meanwhile.
                    if (found) begin
                        winner      <= sel;
                        grant       <= 4'b0001 << sel;
                        break_addr  <= addr_arr[sel];
                        break_wdata <= wdata_arr[sel];
                        to_disk     <= ~dev_wr[sel];
                    end
                end
                ST_REQ: begin
                    if (break_in_prog) wdog <= 3'd0;
                end
                ST_BUSY: begin
                    wdog <= wdog + 3'd1;
                    if (wdog_fire) break_err <= 1'b1;
                end
                ST_DONE: begin
                    grant       <= 4'd0;
                    break_count <= break_count + 12'd1;
                    ptr         <= winner + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Decoded purely from registered state, so both are glitch-free.
    assign data_break = (state == ST_REQ);
    assign done       = (state == ST_DONE) ? grant : 4'd0;
    assign fsm_state  = state;

endmodule
